// File: rtl/gray_arb_pkg.sv
// gray_arb_pkg: default sizes, id-width helper and output-slot state encoding
package gray_arb_pkg;
   localparam int N_REQ_D = 4;
   localparam int W_D     = 4;
   localparam int CNT_W_D = 16;
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;
   function automatic int id_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/gray_to_bin_w.sv
// gray_to_bin_w: combinational Gray-to-binary converter
module gray_to_bin_w #(
   parameter int W = 4
) (
   input  logic [W-1:0] g,
   output logic [W-1:0] b
);
   // each binary bit is the parity of all Gray bits at or above it
   for (genvar i = 0; i < W; i++) begin : g_bit
      assign b[i] = ^(g >> i);
   end
endmodule

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin sharing of one Gray-to-binary converter with a one-entry output slot
module gray_conv_arbiter
   import gray_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_D,
   parameter int W     = W_D,
   parameter int CNT_W = CNT_W_D
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*W-1:0]        req_gray,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [W-1:0]              out_bin,
   output logic [W-1:0]              out_gray,
   output logic [id_w(N_REQ)-1:0]    out_id,
   output logic [CNT_W-1:0]          conv_count
);
   localparam int IW = id_w(N_REQ);
   slot_t         state, state_nx;
   logic [IW-1:0] rr_ptr, win;
   logic          found, can_take, take;
   logic [W-1:0]  win_gray, win_bin;
   // scan from the far end so the requester closest to rr_ptr is written last and wins
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
            win   = IW'((int'(rr_ptr) + k) % N_REQ);
            found = 1'b1;
         end
      end
   end
   assign can_take  = !out_valid | out_ready;
   assign take      = rst_n & found & can_take;
   assign req_ready = take ? (N_REQ'(1) << win) : '0;
   assign win_gray  = req_gray[win*W +: W];
   gray_to_bin_w #(.W(W)) u_conv (
      .g(win_gray),
      .b(win_bin)
   );
   always_ff @(posedge clk) state <= !rst_n ? EMPTY : state_nx;
   always_comb state_nx = take ? FULL : (out_ready ? EMPTY : state);
   always_comb out_valid = (state == FULL);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_gray   <= '0;
         out_bin    <= '0;
         out_id     <= '0;
         rr_ptr     <= '0;
         conv_count <= '0;
      end else if (take) begin
         out_gray   <= win_gray;
         out_bin    <= win_bin;
         out_id     <= win;
         rr_ptr     <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
         conv_count <= conv_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb_gray_conv_arbiter: vector table plus directed sequences for the shared Gray converter
module tb_gray_conv_arbiter;
   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [15:0] req_gray;
   logic [3:0]  req_ready;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_bin;
   logic [3:0]  out_gray;
   logic [1:0]  out_id;
   logic [15:0] conv_count;
   int          checks = 0;
   int          errors = 0;

   gray_conv_arbiter #(.N_REQ(4), .W(4), .CNT_W(16)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_gray(req_gray),
      .req_ready(req_ready),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_bin(out_bin),
      .out_gray(out_gray),
      .out_id(out_id),
      .conv_count(conv_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  v;
      logic [15:0] g;
      logic        ordy;
      logic [3:0]  rr;
      logic        ov;
      logic [3:0]  bin;
      logic [3:0]  gray;
      logic [1:0]  id;
      logic [15:0] cnt;
   } vec_t;
   vec_t tbl[21];

   function automatic logic [3:0] g2b(input logic [3:0] g);
      logic [3:0] b;
      b[3] = g[3];
      for (int k = 2; k >= 0; k--) b[k] = b[k+1] ^ g[k];
      return b;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic [3:0] v, input logic [15:0] g, input logic ordy,
                       input logic [3:0] rr, input logic ov, input logic [3:0] bin,
                       input logic [3:0] gray, input logic [1:0] id, input logic [15:0] cnt);
      @(negedge clk);
      req_valid = v;
      req_gray  = g;
      out_ready = ordy;
      #1 check("req_ready", 32'(req_ready), 32'(rr));
      @(posedge clk);
      #1;
      check("out_valid", 32'(out_valid), 32'(ov));
      check("out_bin", 32'(out_bin), 32'(bin));
      check("out_gray", 32'(out_gray), 32'(gray));
      check("out_id", 32'(out_id), 32'(id));
      check("conv_count", 32'(conv_count), 32'(cnt));
   endtask

   // requesters must hold valid and word until granted
   logic [3:0]  pv, pr;
   logic [15:0] pg;
   logic        prst;
   initial begin
      pv = '0; pr = '0; pg = '0; prst = 1'b0;
   end
   always @(posedge clk) begin
      if (prst) begin
         for (int i = 0; i < 4; i++) begin
            if (pv[i] && !pr[i] && (!req_valid[i] || req_gray[i*4 +: 4] != pg[i*4 +: 4])) begin
               errors++;
               $display("FAIL req_hold: requester %0d changed before grant at %0t", i, $time);
            end
         end
      end
      pv   <= req_valid;
      pr   <= req_ready;
      pg   <= req_gray;
      prst <= rst_n;
   end

   initial begin
      logic [15:0] cnt;
      localparam logic [15:0] G = 16'hEB53;
      tbl[0]  = '{4'b0100, G, 1'b1, 4'b0100, 1'b1, 4'b1101, 4'b1011, 2'd2, 16'd1};
      tbl[1]  = '{4'b0000, G, 1'b1, 4'b0000, 1'b0, 4'b1101, 4'b1011, 2'd2, 16'd1};
      tbl[2]  = '{4'b1000, G, 1'b1, 4'b1000, 1'b1, 4'b1011, 4'b1110, 2'd3, 16'd2};
      tbl[3]  = '{4'b0000, G, 1'b1, 4'b0000, 1'b0, 4'b1011, 4'b1110, 2'd3, 16'd2};
      tbl[4]  = '{4'b1111, G, 1'b1, 4'b0001, 1'b1, 4'b0010, 4'b0011, 2'd0, 16'd3};
      tbl[5]  = '{4'b1111, G, 1'b1, 4'b0010, 1'b1, 4'b0110, 4'b0101, 2'd1, 16'd4};
      tbl[6]  = '{4'b1111, G, 1'b1, 4'b0100, 1'b1, 4'b1101, 4'b1011, 2'd2, 16'd5};
      tbl[7]  = '{4'b1111, G, 1'b1, 4'b1000, 1'b1, 4'b1011, 4'b1110, 2'd3, 16'd6};
      tbl[8]  = '{4'b1111, G, 1'b1, 4'b0001, 1'b1, 4'b0010, 4'b0011, 2'd0, 16'd7};
      tbl[9]  = '{4'b1111, G, 1'b1, 4'b0010, 1'b1, 4'b0110, 4'b0101, 2'd1, 16'd8};
      tbl[10] = '{4'b1111, G, 1'b0, 4'b0000, 1'b1, 4'b0110, 4'b0101, 2'd1, 16'd8};
      tbl[11] = '{4'b1111, G, 1'b0, 4'b0000, 1'b1, 4'b0110, 4'b0101, 2'd1, 16'd8};
      tbl[12] = '{4'b1111, G, 1'b0, 4'b0000, 1'b1, 4'b0110, 4'b0101, 2'd1, 16'd8};
      tbl[13] = '{4'b1111, G, 1'b1, 4'b0100, 1'b1, 4'b1101, 4'b1011, 2'd2, 16'd9};
      tbl[14] = '{4'b1011, G, 1'b1, 4'b1000, 1'b1, 4'b1011, 4'b1110, 2'd3, 16'd10};
      tbl[15] = '{4'b0011, G, 1'b1, 4'b0001, 1'b1, 4'b0010, 4'b0011, 2'd0, 16'd11};
      tbl[16] = '{4'b0010, G, 1'b1, 4'b0010, 1'b1, 4'b0110, 4'b0101, 2'd1, 16'd12};
      tbl[17] = '{4'b0000, G, 1'b1, 4'b0000, 1'b0, 4'b0110, 4'b0101, 2'd1, 16'd12};
      tbl[18] = '{4'b0001, 16'h0008, 1'b1, 4'b0001, 1'b1, 4'b1111, 4'b1000, 2'd0, 16'd13};
      tbl[19] = '{4'b0001, 16'h0006, 1'b1, 4'b0001, 1'b1, 4'b0100, 4'b0110, 2'd0, 16'd14};
      tbl[20] = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'b0100, 4'b0110, 2'd0, 16'd14};

      rst_n = 1'b0; req_valid = 4'hF; req_gray = G; out_ready = 1'b1;
      @(negedge clk);
      check("reset_req_ready", 32'(req_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_req_ready_held", 32'(req_ready), 32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_bin", 32'(out_bin), 32'd0);
      check("reset_conv_count", 32'(conv_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; req_valid = 4'h0;

      foreach (tbl[i])
         step(tbl[i].v, tbl[i].g, tbl[i].ordy, tbl[i].rr, tbl[i].ov,
              tbl[i].bin, tbl[i].gray, tbl[i].id, tbl[i].cnt);

      cnt = 16'd14;
      for (int i = 0; i < 16; i++) begin
         cnt++;
         step(4'b0001, 16'(i), 1'b1, 4'b0001, 1'b1, g2b(4'(i)), 4'(i), 2'd0, cnt);
      end
      step(4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, g2b(4'hF), 4'hF, 2'd0, cnt);

      cnt++;
      step(4'b0001, 16'h0005, 1'b0, 4'b0001, 1'b1, 4'b0110, 4'b0101, 2'd0, cnt);
      step(4'b0000, 16'h0005, 1'b0, 4'b0000, 1'b1, 4'b0110, 4'b0101, 2'd0, cnt);
      @(negedge clk);
      rst_n = 1'b0; req_valid = 4'b0001; out_ready = 1'b0;
      #1 check("midreset_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      check("midreset_out_valid", 32'(out_valid), 32'd0);
      check("midreset_out_bin", 32'(out_bin), 32'd0);
      check("midreset_out_id", 32'(out_id), 32'd0);
      check("midreset_conv_count", 32'(conv_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; req_valid = 4'hF; req_gray = G; out_ready = 1'b1;
      #1 check("post_reset_first_grant", 32'(req_ready), 32'b0001);
      repeat (65535) @(posedge clk);
      #1 check("count_at_ffff", 32'(conv_count), 32'hFFFF);
      @(posedge clk);
      #1;
      check("count_wrap", 32'(conv_count), 32'd0);
      check("wrap_out_id", 32'(out_id), 32'd3);
      check("wrap_out_valid", 32'(out_valid), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
